sipo_register: RTL
==================

# sipo_register

Serial-in/parallel-out receiver: the capture end of the PISO serial link. Samples one bit per qualified clock, LSB first (matching the PISO's right-shift, q[0]-first order), and assembles WIDTH-bit words. Each completed word is presented on a held output register with a valid/ack handshake and a sticky overrun flag. Sits at the link sink; feeds the parallel consumer.

## Interface
- WIDTH, 4, data word width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (sampled on rising clk)
- serial_in  input  1  serial data bit
- shift_en  input  1  qualifies serial_in this cycle
- clear  input  1  synchronous abort: discards partial word, clears overrun
- out_ack  input  1  consumer accepts parallel_out this cycle
- parallel_out  output  WIDTH  last completed word
- out_valid  output  1  parallel_out holds an unaccepted word
- overrun  output  1  sticky: a word completed while the previous one was unaccepted
- busy  output  1  partial word in progress (bit count ≠ 0)
- parity_err  output  1  parity result of current word (only with SIPO_PARITY_EN; else tied 0)

## Operation
- Shift register sr[WIDTH-1:0]; on shift_en: sr <= {serial_in, sr[WIDTH-1:1]}; first bit received ends in bit 0.
- Bit counter cnt, 0..WIDTH-1 (0..WIDTH with parity); increments on shift_en, returns to 0 on word completion.
- FSM: S_DATA (collecting data bits) -> S_PARITY (parity enabled, after WIDTH-th data bit) -> S_DATA. Without parity, FSM stays in S_DATA.
- Completion = shift_en on the final bit of the frame (WIDTH-th data bit, or parity bit).
- On completion:
  - out_valid=0, or out_ack=1 this cycle: parallel_out <= assembled word (incl. the bit sampled this cycle); out_valid <= 1.
  - out_valid=1 and out_ack=0: new word dropped, parallel_out unchanged, overrun <= 1.
- out_ack with out_valid=1 and no completion: out_valid <= 0. out_ack with out_valid=0: ignored.
- clear: cnt <= 0, FSM <= S_DATA, sr <= 0, overrun <= 0; parallel_out/out_valid untouched. clear beats shift_en in the same cycle (bit discarded). clear with out_ack: ack still honoured.
- busy = (cnt ≠ 0) or FSM = S_PARITY.
- Reset: sr=0, cnt=0, FSM=S_DATA, parallel_out=0, out_valid=0, overrun=0, busy=0, parity_err=0. Reset dominates all inputs, including mid-word; partial word lost.

## Timing
- All outputs registered except busy (decoded from registered cnt/FSM, no input path).
- Latency: final bit sampled at edge N -> parallel_out/out_valid updated from edge N, visible in cycle N+1.
- Back-to-back: with shift_en held high and out_ack asserted each valid cycle, one word every WIDTH cycles (WIDTH+1 with parity), no gaps.
- shift_en low holds all state; gaps between bits of a word are allowed, any length.
- Completion and out_ack in same cycle: out_valid stays 1 with new word, no overrun.

## Configuration
- SIPO_PARITY_EN defined: frame = WIDTH data bits then one even-parity bit. On completion parity_err <= XOR(data word, parity bit); registered alongside parallel_out, same load/drop rules (not updated on an overrun drop). Reset/clear of parity_err: reset only.
- SIPO_PARITY_EN undefined: no parity state or bit; frame = WIDTH bits; parity_err tied 0.

## Test plan
- Reset: hold reset=0 mid-word (2 bits shifted) -> after release all outputs 0, next 4 bits form a fresh word.
- Basic: WIDTH=4, shift_en=1, serial_in 1,1,0,1 -> cycle after 4th edge parallel_out=4'b1011, out_valid=1; loopback from PISO loaded 4'b1011 gives the same.
- Handshake: ack 3 cycles after valid -> out_valid drops next cycle; continuous stream 1011 then 0011 (bits 1,1,0,0) with ack on completion edge -> out_valid stays 1, parallel_out 1011 -> 0011, overrun=0.
- Overrun: no ack, second word 1,0,0,0 completes -> parallel_out stays 1011, overrun=1; clear -> overrun=0, out_valid still 1.
- Clear/gaps: 2 bits, clear with shift_en=1, then 1,0,1,0 with idle gaps of 3 cycles -> parallel_out=4'b0101, busy 0 after clear.
- Parity (SIPO_PARITY_EN): bits 1,1,0,1,1 -> parity_err=0, parallel_out=1011; bits 1,1,0,1,0 -> parity_err=1.

Source files
------------

// File: rtl/sipo_register.sv
// ============================================================================
//  Module      : sipo_register
//  Description : Serial-in/parallel-out receiver, LSB first, with a held output
//                word, valid/ack handshake and sticky overrun flag.
//                Optional even-parity frame bit: define SIPO_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_register #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             out_ack,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             overrun,
    output logic             busy,
    output logic             parity_err
);

    localparam int                 c_cnt_w     = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_data = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [0:0] {
        S_DATA   = 1'b0,
        S_PARITY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               w_complete;
    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   w_sr_shift;
    logic [WIDTH-1:0]   w_word;
    logic [WIDTH-1:0]   r_parallel_out;
    logic               r_out_valid;
    logic               r_overrun;
    logic               w_load;

    assign w_sr_shift = {serial_in, r_sr[WIDTH-1:1]};
    // A completed word is accepted when the holding register is free or being acked.
    assign w_load     = w_complete && (!r_out_valid || out_ack);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_complete   = 1'b0;
        if (clear) begin
            w_state_next = S_DATA;
            w_cnt_next   = '0;
        end else if (shift_en) begin
            case (r_state)
                S_DATA: begin
                    if (r_cnt == c_last_data) begin
`ifdef SIPO_PARITY_EN
                        w_state_next = S_PARITY;
                        w_cnt_next   = r_cnt + c_cnt_one;
`else
                        w_cnt_next   = '0;
                        w_complete   = 1'b1;
`endif
                    end else begin
                        w_cnt_next = r_cnt + c_cnt_one;
                    end
                end
                S_PARITY: begin
                    w_state_next = S_DATA;
                    w_cnt_next   = '0;
                    w_complete   = 1'b1;
                end
                default: begin
                    w_state_next = S_DATA;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sr           <= '0;
            r_parallel_out <= '0;
            r_out_valid    <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (clear) begin
                r_sr <= '0;
            end else if (shift_en && (r_state == S_DATA)) begin
                r_sr <= w_sr_shift;
            end

            if (w_load) begin
                r_parallel_out <= w_word;
                r_out_valid    <= 1'b1;
            end else if (w_complete) begin
                r_overrun      <= 1'b1;
            end else if (out_ack) begin
                r_out_valid    <= 1'b0;
            end

            if (clear) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    logic r_parity_err;

    // The parity bit is never shifted in, so r_sr already holds the data word.
    assign w_word = r_sr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_parity_err <= 1'b0;
        end else if (w_load) begin
            r_parity_err <= (^r_sr) ^ serial_in;
        end
    end

    assign parity_err = r_parity_err;
`else
    logic w_unused_sr0;

    assign w_word       = w_sr_shift;
    assign w_unused_sr0 = r_sr[0];
    assign parity_err   = 1'b0;
`endif

    assign parallel_out = r_parallel_out;
    assign out_valid    = r_out_valid;
    assign overrun      = r_overrun;
    assign busy         = (r_cnt != '0) || (r_state == S_PARITY);

endmodule

`default_nettype wire
